// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared register map, FSM encodings and helpers for irq_ctrl
package irq_ctrl_pkg;

  // Register offsets from BASE
  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_VEC  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  // Dispatch FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INSERV = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // VEC value when no source is in service
  localparam logic [7:0] VEC_NONE = 8'hFF;

  // Priority encoder result
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } prio_t;

  // Mask with the low n bits set; unimplemented source bits stay zero
  function automatic logic [7:0] src_bits(input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - CPU byte bus between the processor and irq_ctrl
interface irq_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wren;
  logic        sel;
  logic [7:0]  rdata;

  modport master (output addr, output wdata, output wren, input sel, input rdata);
  modport slave  (input addr, input wdata, input wren, output sel, output rdata);
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed priority encoder, lowest set index wins
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  output prio_t           res
);

  // Scan from the top down so the lowest set bit is the last assignment
  always_comb begin
    res = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        res.valid = 1'b1;
        res.idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-latched interrupt controller with toggle IRQ output
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC = 8,
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] i_src,
  irq_ctrl_if.slave       bus,
  output logic            o_irq
);

  localparam logic [7:0] SRC_MASK = src_bits(NSRC);

  logic [7:0]  src_q, src_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  vec_q, vec_d;
  logic [1:0]  state_q, state_d;
  logic        irq_q, irq_d;

  logic [7:0]  src_ext;
  logic [7:0]  rise;
  logic [7:0]  req;
  logic [7:0]  dispatch_clr;
  logic [7:0]  w1c;
  logic [15:0] off;
  logic        wr_pend, wr_mask, wr_eoi;
  prio_t       pick;

  // Widen the source lines to the 8-bit register width
  always_comb begin
    src_ext = '0;
    for (int i = 0; i < NSRC; i++) src_ext[i] = i_src[i];
  end

  // Address decode and combinational read mux
  always_comb begin
    off       = bus.addr - BASE;
    bus.sel   = (off[15:2] == 14'd0);
    wr_pend   = bus.wren && bus.sel && (off[1:0] == REG_PEND);
    wr_mask   = bus.wren && bus.sel && (off[1:0] == REG_MASK);
    wr_eoi    = bus.wren && bus.sel && (off[1:0] == REG_EOI);
    case (off[1:0])
      REG_PEND: bus.rdata = pend_q;
      REG_MASK: bus.rdata = mask_q;
      REG_VEC:  bus.rdata = vec_q;
      default:  bus.rdata = 8'h00;
    endcase
  end

  assign req = pend_q & mask_q;

  irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req (req[NSRC-1:0]),
    .res (pick)
  );

  // Next-state logic: edge detect, register writes and dispatch FSM
  always_comb begin
    src_d        = src_ext;
    mask_d       = mask_q;
    vec_d        = vec_q;
    state_d      = state_q;
    irq_d        = irq_q;
    dispatch_clr = '0;
    rise         = src_ext & ~src_q;
    w1c          = wr_pend ? bus.wdata : 8'h00;

    if (wr_mask) mask_d = bus.wdata & SRC_MASK;

    case (state_q)
      ST_IDLE: begin
        if (pick.valid) begin
          dispatch_clr[pick.idx] = 1'b1;
          vec_d   = {5'b0, pick.idx};
          irq_d   = ~irq_q;
          state_d = ST_INSERV;
        end
      end
      ST_INSERV: begin
        if (wr_eoi) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        vec_d   = VEC_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        vec_d   = VEC_NONE;
        state_d = ST_IDLE;
      end
    endcase

    // New edges are ORed in last so they survive a same-cycle clear
    pend_d = ((pend_q & ~w1c & ~dispatch_clr) | rise) & SRC_MASK;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      vec_q   <= VEC_NONE;
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      src_q   <= src_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  assign o_irq = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl
module tb_irq_ctrl;

  localparam logic [15:0] BASE = 16'hFF00;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_src;
  logic       o_irq;

  irq_ctrl_if bus ();

  irq_ctrl #(.NSRC(8), .BASE(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_src (i_src),
    .bus   (bus),
    .o_irq (o_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wren  = 1'b1;
    tick();
    bus.wren  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Reference model: pending set, enable set, in-service vector, busy/hold flags
  logic [7:0] m_pend, m_mask, m_vec, m_srcq;
  logic       m_irq;
  int         m_state;  // 0 idle, 1 serving, 2 cooling down after EOI

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_vec = 8'hFF; m_srcq = 0; m_irq = 0; m_state = 0;
  endtask

  task automatic model_step(input logic [7:0] src, input logic w, input logic [15:0] a,
                            input logic [7:0] d);
    logic [7:0] np, nm, nv, active;
    logic       ni;
    int         ns, off;
    bit         hit;
    off = int'(a) - int'(BASE);
    hit = w && (off >= 0) && (off <= 3);
    np = m_pend; nm = m_mask; nv = m_vec; ni = m_irq; ns = m_state;
    if (hit && off == 0) np = np & ~d;
    if (hit && off == 1) nm = d;
    active = m_pend & m_mask;
    if (m_state == 0) begin
      if (active != 0) begin
        for (int i = 7; i >= 0; i--) if (active[i]) nv = 8'(i);
        np[nv[2:0]] = 1'b0;
        ni = ~m_irq;
        ns = 1;
      end
    end else if (m_state == 1) begin
      if (hit && off == 3) ns = 2;
    end else begin
      nv = 8'hFF;
      ns = 0;
    end
    np = np | (src & ~m_srcq);
    m_pend = np; m_mask = nm; m_vec = nv; m_irq = ni; m_state = ns; m_srcq = src;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        wren;
    logic [7:0]  wdata;
    logic        exp_sel;
    logic [7:0]  exp_mask;
  } vec_t;

  vec_t tbl[8];

  logic [7:0] rv;
  logic       irq0;

  initial begin
    rst_n = 1'b0; i_src = 0;
    bus.addr = 0; bus.wdata = 0; bus.wren = 0;
    do_reset();

    // Reset state
    check("rst_irq", {7'b0, o_irq}, 8'h00);
    rd(BASE + 16'd0, rv); check("rst_pend", rv, 8'h00);
    rd(BASE + 16'd1, rv); check("rst_mask", rv, 8'h00);
    rd(BASE + 16'd2, rv); check("rst_vec", rv, 8'hFF);
    rd(BASE + 16'd3, rv); check("rst_eoi", rv, 8'h00);

    // Decode / MASK write table
    tbl[0] = '{BASE + 16'd1, 1'b1, 8'h5A, 1'b1, 8'h5A};
    tbl[1] = '{BASE + 16'd5, 1'b1, 8'hFF, 1'b0, 8'h5A};
    tbl[2] = '{16'h0001,     1'b1, 8'h11, 1'b0, 8'h5A};
    tbl[3] = '{BASE + 16'd2, 1'b1, 8'h00, 1'b1, 8'h5A};
    tbl[4] = '{BASE - 16'd1, 1'b1, 8'h22, 1'b0, 8'h5A};
    tbl[5] = '{BASE + 16'd1, 1'b0, 8'h33, 1'b1, 8'h5A};
    tbl[6] = '{BASE + 16'd4, 1'b0, 8'h00, 1'b0, 8'h5A};
    tbl[7] = '{BASE + 16'd1, 1'b1, 8'h00, 1'b1, 8'h00};
    for (int i = 0; i < 8; i++) begin
      bus.addr = tbl[i].addr; bus.wdata = tbl[i].wdata; bus.wren = tbl[i].wren;
      #1;
      check($sformatf("tbl%0d_sel", i), {7'b0, bus.sel}, {7'b0, tbl[i].exp_sel});
      tick();
      bus.wren = 1'b0;
      rd(BASE + 16'd1, rv);
      check($sformatf("tbl%0d_mask", i), rv, tbl[i].exp_mask);
    end

    // 1: single source, two-cycle latency
    wr(BASE + 16'd1, 8'h01);
    i_src = 8'h01;
    tick();
    check("t1_irq_n", {7'b0, o_irq}, 8'h00);
    tick();
    check("t1_irq_n1", {7'b0, o_irq}, 8'h01);
    rd(BASE + 16'd2, rv); check("t1_vec", rv, 8'h00);
    rd(BASE + 16'd0, rv); check("t1_pend", rv, 8'h00);
    i_src = 8'h00;
    wr(BASE + 16'd3, 8'h00);
    tick();
    rd(BASE + 16'd2, rv); check("t1_vec_free", rv, 8'hFF);

    // 2: two simultaneous sources, priority then EOI re-dispatch
    wr(BASE + 16'd1, 8'hFF);
    i_src = 8'h24;
    tick();
    tick();
    check("t2_irq", {7'b0, o_irq}, 8'h00);
    rd(BASE + 16'd2, rv); check("t2_vec", rv, 8'h02);
    rd(BASE + 16'd0, rv); check("t2_pend", rv, 8'h20);
    i_src = 8'h00;
    wr(BASE + 16'd3, 8'hA5);
    check("t2_irq_hold", {7'b0, o_irq}, 8'h00);
    tick();
    check("t2_irq_idle", {7'b0, o_irq}, 8'h00);
    tick();
    check("t2_irq_again", {7'b0, o_irq}, 8'h01);
    rd(BASE + 16'd2, rv); check("t2_vec2", rv, 8'h05);
    wr(BASE + 16'd3, 8'h00);
    tick();

    // 3: masked pending, dispatch on unmask
    wr(BASE + 16'd1, 8'h00);
    i_src = 8'h08;
    tick();
    i_src = 8'h00;
    tick();
    rd(BASE + 16'd0, rv); check("t3_pend", rv, 8'h08);
    check("t3_no_irq", {7'b0, o_irq}, 8'h01);
    wr(BASE + 16'd1, 8'h08);
    check("t3_irq_wait", {7'b0, o_irq}, 8'h01);
    tick();
    check("t3_irq", {7'b0, o_irq}, 8'h00);
    rd(BASE + 16'd2, rv); check("t3_vec", rv, 8'h03);
    wr(BASE + 16'd3, 8'h00);
    tick();

    // 4: set beats same-cycle write-1-to-clear
    wr(BASE + 16'd1, 8'h00);
    i_src = 8'h10;
    tick();
    i_src = 8'h00;
    tick();
    rd(BASE + 16'd0, rv); check("t4_pend", rv, 8'h10);
    i_src = 8'h10;
    wr(BASE + 16'd0, 8'h10);
    i_src = 8'h00;
    rd(BASE + 16'd0, rv); check("t4_set_wins", rv, 8'h10);
    wr(BASE + 16'd0, 8'h10);
    rd(BASE + 16'd0, rv); check("t4_cleared", rv, 8'h00);

    // 5: EOI while idle is ignored
    irq0 = o_irq;
    wr(BASE + 16'd3, 8'hFF);
    tick();
    check("t5_irq", {7'b0, o_irq}, {7'b0, irq0});
    rd(BASE + 16'd2, rv); check("t5_vec", rv, 8'hFF);
    rd(BASE + 16'd3, rv); check("t5_eoi_rd", rv, 8'h00);
    bus.addr = BASE + 16'd4; #1;
    check("t5_sel_out", {7'b0, bus.sel}, 8'h00);
    wr(BASE + 16'd1, 8'h01);
    i_src = 8'h01;
    tick();
    i_src = 8'h00;
    tick();
    check("t5_dispatch", {7'b0, o_irq}, {7'b0, ~irq0});

    // 6: asynchronous reset while in service
    check("t6_pre_irq", {7'b0, o_irq}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_irq", {7'b0, o_irq}, 8'h00);
    rd(BASE + 16'd2, rv); check("t6_vec", rv, 8'hFF);
    rd(BASE + 16'd1, rv); check("t6_mask", rv, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the reference model
    model_reset();
    #1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [7:0]  s, d;
      logic        w;
      logic [15:0] a;
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : i_src;
      w = ($urandom_range(0, 9) < 3);
      a = BASE + 16'($urandom_range(0, 5));
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0 && a == BASE + 16'd1) d = d | 8'h0F;
      i_src = s; bus.addr = a; bus.wdata = d; bus.wren = w;
      model_step(s, w, a, d);
      tick();
      bus.wren = 1'b0;
      check("rnd_irq", {7'b0, o_irq}, {7'b0, m_irq});
      rd(BASE + 16'd0, rv); check("rnd_pend", rv, m_pend);
      rd(BASE + 16'd1, rv); check("rnd_mask", rv, m_mask);
      rd(BASE + 16'd2, rv); check("rnd_vec", rv, m_vec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
